piece_stamper: RTL and testbench
================================

PIECE_STAMPER -- requirements
Module: piece_stamper

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Parameter BOARD_W, default 12, SHALL give the board width in cells.
REQ-003 Parameter BOARD_H, default 21, SHALL give the board height in cells.
REQ-004 Parameter PIECE_N, default 4, SHALL give the piece box edge; the box holds PIECE_N x PIECE_N cells.
REQ-005 Parameter DATA_W, default 8, SHALL give the cell data width.
REQ-006 Parameter ADDR_W, default 8, SHALL give the address width; BOARD_W*BOARD_H <= 2^ADDR_W SHALL hold.
REQ-007 Port clk  in  1  SHALL be the rising-edge clock.
REQ-008 Port rst  in  1  SHALL be the synchronous active-high reset.
REQ-009 Port start  in  1  SHALL be a one-cycle operation request.
REQ-010 Port mode  in  2  SHALL select the operation: 00 check, 01 place, 10 erase, 11 check-then-place.
REQ-011 Port pos_x  in  ADDR_W  SHALL give the board column of box cell (0,0).
REQ-012 Port pos_y  in  ADDR_W  SHALL give the board row of box cell (0,0).
REQ-013 Port shape  in  PIECE_N*PIECE_N  SHALL be the occupancy mask; bit r*PIECE_N+c is box cell (row r, col c).
REQ-014 Port color  in  DATA_W  SHALL be the value written for occupied cells in place mode.
REQ-015 Port we  out  1  SHALL be the board memory write enable.
REQ-016 Port addr  out  ADDR_W  SHALL be the board memory address.
REQ-017 Port wdata  out  DATA_W  SHALL be the board memory write data.
REQ-018 Port rdata  in  DATA_W  SHALL be the board memory read data, valid one cycle after addr is presented.
REQ-019 Port busy  out  1  SHALL be high while an operation is in progress.
REQ-020 Port done  out  1  SHALL pulse high for one cycle when an operation completes.
REQ-021 Port collision  out  1  SHALL carry the result of the last operation.

Function
REQ-022 States SHALL be IDLE, RD_ADDR, RD_CMP, WRITE, and FINISH.
REQ-023 In IDLE with start=1, the block SHALL latch mode, pos_x, pos_y, shape, and color, clear collision, and set cell index k=0.
- Modes 00 and 11 SHALL go to RD_ADDR.
- Modes 01 and 10 SHALL go to WRITE.
REQ-024 A start that arrives while busy=1 SHALL be ignored, and the latched inputs SHALL be unaffected.
REQ-025 Cell k SHALL be scanned row-major: r=k/PIECE_N, c=k%PIECE_N; board column = pos_x+c and board row = pos_y+r, both computed without truncation.
REQ-026 A cell SHALL be out of bounds (OOB) when its column >= BOARD_W or its row >= BOARD_H.
REQ-027 For an in-bounds cell, the address SHALL be row*BOARD_W+column.
REQ-028 RD_ADDR SHALL present addr for cell k with we=0 and then go to RD_CMP.
REQ-029 RD_CMP SHALL check the cell when its mask bit is set, then increment k.
- Collision SHALL set if the cell is OOB or rdata != 0.
- After the last cell, mode 00 SHALL go to FINISH.
- After the last cell, mode 11 with collision=1 SHALL go to FINISH with no writes.
- After the last cell, mode 11 with collision=0 SHALL go to WRITE with k=0.
- Otherwise RD_CMP SHALL return to RD_ADDR.
REQ-030 Each WRITE cycle SHALL handle one cell k and then increment k; after the last cell it SHALL go to FINISH.
- we=1 SHALL be driven only when the mask bit is set and the cell is in bounds.
- wdata SHALL be color (modes 01 and 11) or 0 (mode 10).
REQ-031 In modes 01 and 10, an occupied OOB cell SHALL set collision and SHALL NOT be written.
REQ-032 Latency SHALL be fixed regardless of mask contents:
- Each cell SHALL take 2 cycles in the check phase and 1 cycle in the write phase.
- FINISH SHALL last 1 cycle, with done=1 and busy=0 in that cycle.
REQ-033 busy SHALL be 1 from the cycle after start is accepted through the last phase cycle.
REQ-034 collision SHALL hold its value from FINISH until the next accepted start.
REQ-035 we SHALL be 0 in every state except WRITE.

Reset
REQ-036 When rst=1, the next edge SHALL force IDLE with we=0, addr=0, wdata=0, busy=0, done=0, collision=0, and k=0, including mid-operation.
REQ-037 No memory write SHALL occur in the cycle after rst is sampled high; an aborted operation SHALL NOT pulse done.

Verification
REQ-038 Place: mode=01, pos=(4,19), shape=16'h000F, color=8'h5A -> we=1 at addr 232,233,234,235 in write cycles 0-3; done in cycle 17; collision=0.
REQ-039 Check-then-place onto an occupied cell: preload addr 233 with 8'h11, mode=11, same piece -> no we during the 32 check cycles, no writes at all, done in cycle 33, collision=1.
REQ-040 OOB: mode=01, pos=(10,0), shape=16'h000F -> writes only to addr 10 and 11, collision=1.
REQ-041 Erase: mode=10, pos=(0,0), shape=16'h0033 -> wdata=0 written to addr 0,1,12,13.
REQ-042 Busy and reset: a start while busy -> ignored; rst asserted at write cycle 2 -> we=0 on the next edge, no done, collision=0, and the next start is accepted normally.

Source files
------------

// File: rtl/piece_stamper.sv
// Stamps a PIECE_N x PIECE_N occupancy mask onto a board memory: collision check,
// place, erase, or check-then-place, with a fixed cycle count per operation.
module piece_stamper #(
    parameter int unsigned BOARD_W = 12,
    parameter int unsigned BOARD_H = 21,
    parameter int unsigned PIECE_N = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [ADDR_W-1:0]            pos_x,
    input  logic [ADDR_W-1:0]            pos_y,
    input  logic [PIECE_N*PIECE_N-1:0]   shape,
    input  logic [DATA_W-1:0]            color,
    output logic                         we,
    output logic [ADDR_W-1:0]            addr,
    output logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W-1:0]            rdata,
    output logic                         busy,
    output logic                         done,
    output logic                         collision
);

    localparam int unsigned NC = PIECE_N * PIECE_N;
    localparam int unsigned KW = (NC > 1) ? $clog2(NC) : 1;
    localparam int unsigned CW = ADDR_W + KW + 1;
    localparam int unsigned PW = 2 * CW;

    localparam logic [1:0] M_CHECK  = 2'b00;
    localparam logic [1:0] M_ERASE  = 2'b10;
    localparam logic [1:0] M_CPLACE = 2'b11;

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CMP, WRITE, FINISH} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [1:0]          mode_q, mode_d;
    logic [ADDR_W-1:0]   px_q, px_d, py_q, py_d;
    logic [NC-1:0]       shape_q, shape_d;
    logic [DATA_W-1:0]   color_q, color_d;
    logic                collision_q, collision_d;
    logic                we_q, we_d, busy_q, busy_d, done_q, done_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic [CW-1:0]       cur_col, cur_row, nxt_col, nxt_row;
    logic                cur_oob, nxt_oob, cur_last, hit, coll_acc;

    // Board coordinates are widened so pos + box offset never wraps.
    function automatic logic [CW-1:0] cell_col(input logic [ADDR_W-1:0] px, input logic [KW-1:0] k);
        return CW'(px) + (CW'(k) % CW'(PIECE_N));
    endfunction

    function automatic logic [CW-1:0] cell_row(input logic [ADDR_W-1:0] py, input logic [KW-1:0] k);
        return CW'(py) + (CW'(k) / CW'(PIECE_N));
    endfunction

    function automatic logic cell_oob(input logic [CW-1:0] col, input logic [CW-1:0] row);
        return (col >= CW'(BOARD_W)) || (row >= CW'(BOARD_H));
    endfunction

    function automatic logic [ADDR_W-1:0] cell_addr(input logic [CW-1:0] col, input logic [CW-1:0] row);
        logic [PW-1:0] lin;
        lin = PW'(row) * PW'(BOARD_W) + PW'(col);
        return ADDR_W'(lin);
    endfunction

    // Next-state logic; outputs are computed for the state being entered so they register cleanly.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        mode_d      = mode_q;
        px_d        = px_q;
        py_d        = py_q;
        shape_d     = shape_q;
        color_d     = color_q;
        collision_d = collision_q;

        cur_col  = cell_col(px_q, k_q);
        cur_row  = cell_row(py_q, k_q);
        cur_oob  = cell_oob(cur_col, cur_row);
        cur_last = (k_q == KW'(NC - 1));
        hit      = shape_q[k_q] && (cur_oob || (rdata != '0));
        coll_acc = collision_q || hit;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d      = mode;
                    px_d        = pos_x;
                    py_d        = pos_y;
                    shape_d     = shape;
                    color_d     = color;
                    collision_d = 1'b0;
                    k_d         = '0;
                    state_d     = (mode == M_CHECK || mode == M_CPLACE) ? RD_ADDR : WRITE;
                end
            end
            RD_ADDR: state_d = RD_CMP;
            RD_CMP: begin
                collision_d = coll_acc;
                if (cur_last) begin
                    k_d     = '0;
                    state_d = (mode_q == M_CHECK || coll_acc) ? FINISH : WRITE;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = RD_ADDR;
                end
            end
            WRITE: begin
                if (shape_q[k_q] && cur_oob) collision_d = 1'b1;
                if (cur_last) begin
                    k_d     = '0;
                    state_d = FINISH;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            FINISH: begin
                k_d     = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        nxt_col = cell_col(px_d, k_d);
        nxt_row = cell_row(py_d, k_d);
        nxt_oob = cell_oob(nxt_col, nxt_row);

        busy_d  = (state_d == RD_ADDR) || (state_d == RD_CMP) || (state_d == WRITE);
        done_d  = (state_d == FINISH);
        we_d    = (state_d == WRITE) && shape_d[k_d] && !nxt_oob;
        addr_d  = addr_q;
        if (state_d == RD_ADDR || state_d == WRITE) addr_d = nxt_oob ? '0 : cell_addr(nxt_col, nxt_row);
        wdata_d = '0;
        if (state_d == WRITE && mode_d != M_ERASE) wdata_d = color_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            k_q         <= '0;
            mode_q      <= '0;
            px_q        <= '0;
            py_q        <= '0;
            shape_q     <= '0;
            color_q     <= '0;
            collision_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            mode_q      <= mode_d;
            px_q        <= px_d;
            py_q        <= py_d;
            shape_q     <= shape_d;
            color_q     <= color_d;
            collision_q <= collision_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign we        = we_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;

endmodule

// File: tb/tb_piece_stamper.sv
// Directed bench for piece_stamper: board memory model, per-cycle reference model, literal pins.
module tb_piece_stamper;

    localparam int BW = 12;
    localparam int BH = 21;
    localparam int PN = 4;

    logic        clk;
    logic        rst, start;
    logic [1:0]  mode;
    logic [7:0]  pos_x, pos_y;
    logic [15:0] shape;
    logic [7:0]  color;
    logic        we;
    logic [7:0]  addr, wdata, rdata;
    logic        busy, done, collision;

    piece_stamper dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .pos_x(pos_x), .pos_y(pos_y),
        .shape(shape), .color(color), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .collision(collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board memory with one-cycle read latency and a log of every write.
    logic [7:0]  mem [256];
    logic        clr_mem, pl_en;
    logic [7:0]  pl_addr, pl_data;
    logic [15:0] wr_log [$];

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end
        if (we) begin
            mem[addr] <= wdata;
            wr_log.push_back({addr, wdata});
        end
        rdata <= mem[addr];
    end

    typedef struct {
        bit we;
        int addr;
        int wdata;
        bit busy;
        bit done;
        bit coll;
        bit chk_coll;
    } exp_t;

    exp_t exp_q [$];
    int   checks, errors, cyc, done_cyc, start_cyc, log_base;
    bit   model_coll, cmp_en;
    int   ref_mem [256];

    function automatic exp_t rec(bit w, int a, int d, bit b, bit dn, bit c, bit cc);
        exp_t e;
        e.we = w; e.addr = a; e.wdata = d; e.busy = b; e.done = dn; e.coll = c; e.chk_coll = cc;
        return e;
    endfunction

    task automatic chk(input string name, input int got, input int exp_v);
        checks++;
        if (got != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp_v, cyc);
        end
    endtask

    task automatic compare_cycle();
        exp_t e;
        if (!cmp_en) return;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = rec(0, 0, 0, 0, 0, model_coll, 1);
        chk("we", we, e.we);
        chk("busy", busy, e.busy);
        chk("done", done, e.done);
        if (e.we) begin
            chk("addr", addr, e.addr);
            chk("wdata", wdata, e.wdata);
            ref_mem[e.addr] = e.wdata;
        end
        if (e.chk_coll) chk("collision", collision, e.coll);
        if (done) done_cyc = cyc;
    endtask

    task automatic tick();
        @(negedge clk);
        compare_cycle();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    // Expected outputs per cycle, derived from the cell geometry and the reference board.
    task automatic build(input int m, input int px, input int py, input int shp, input int col);
        bit coll, occ, oob;
        int c, r, a;
        coll = 0;
        exp_q.push_back(rec(0, 0, 0, 0, 0, model_coll, 1));
        if (m == 0 || m == 3) begin
            for (int k = 0; k < PN * PN; k++) begin
                c = px + k % PN; r = py + k / PN;
                oob = (c >= BW) || (r >= BH);
                a = oob ? 0 : r * BW + c;
                occ = shp[k];
                exp_q.push_back(rec(0, 0, 0, 1, 0, 0, 0));
                exp_q.push_back(rec(0, 0, 0, 1, 0, 0, 0));
                if (occ && (oob || ref_mem[a] != 0)) coll = 1;
            end
        end
        if (m == 1 || m == 2 || (m == 3 && !coll)) begin
            for (int k = 0; k < PN * PN; k++) begin
                c = px + k % PN; r = py + k / PN;
                oob = (c >= BW) || (r >= BH);
                a = oob ? 0 : r * BW + c;
                occ = shp[k];
                exp_q.push_back(rec(occ && !oob, a, (m == 2) ? 0 : col, 1, 0, 0, 0));
                if (occ && oob) coll = 1;
            end
        end
        exp_q.push_back(rec(0, 0, 0, 0, 1, coll, 1));
        model_coll = coll;
    endtask

    task automatic run_op(input int m, input int px, input int py, input int shp, input int col,
                          input int inj, input int abort_at);
        int idx;
        done_cyc  = -1;
        log_base  = wr_log.size();
        start_cyc = cyc;
        build(m, px, py, shp, col);
        mode = 2'(m); pos_x = 8'(px); pos_y = 8'(py); shape = 16'(shp); color = 8'(col);
        start = 1'b1;
        tick();
        start = 1'b0;
        idx = 1;
        while (exp_q.size() > 0 && idx < 200) begin
            if (idx == inj) begin
                start = 1'b1; mode = 2'b10; pos_x = 8'd0; pos_y = 8'd0; shape = 16'hFFFF; color = 8'hAA;
            end
            if (idx == abort_at) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                exp_q.delete();
                model_coll = 0;
                break;
            end
            tick();
            start = 1'b0;
            idx++;
        end
        if (exp_q.size() > 0) begin
            chk("op_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        tick();
    endtask

    task automatic clear_board();
        clr_mem = 1'b1;
        tick();
        clr_mem = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
    endtask

    task automatic preload(input int a, input int d);
        pl_en = 1'b1; pl_addr = 8'(a); pl_data = 8'(d);
        tick();
        pl_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic chk_log(input string name, input int i, input int ea, input int ed);
        logic [15:0] ent;
        ent = (log_base + i < wr_log.size()) ? wr_log[log_base + i] : 16'hFFFF;
        chk({name, "_addr"}, int'(ent[15:8]), ea);
        chk({name, "_data"}, int'(ent[7:0]), ed);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        checks = 0; errors = 0; cyc = 0; done_cyc = -1;
        rst = 1'b1; start = 1'b0; mode = 2'b00; pos_x = 8'd0; pos_y = 8'd0;
        shape = 16'h0; color = 8'h0;
        clr_mem = 1'b1; pl_en = 1'b0; pl_addr = 8'h0; pl_data = 8'h0;
        cmp_en = 0; model_coll = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; clr_mem = 1'b0;

        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_we", we, 0);
        chk("reset_addr", addr, 0);
        chk("reset_wdata", wdata, 0);
        chk("reset_collision", collision, 0);
        cmp_en = 1;
        tick();

        // Place at the bottom rows.
        run_op(1, 4, 19, 16'h000F, 8'h5A, -1, -1);
        chk("place_nwr", wr_log.size() - log_base, 4);
        for (int i = 0; i < 4; i++) chk_log("place", i, 232 + i, 8'h5A);
        chk("place_latency", done_cyc - start_cyc, 17);
        chk("place_coll", collision, 0);

        // Check-then-place onto an occupied cell.
        clear_board();
        preload(233, 8'h11);
        run_op(3, 4, 19, 16'h000F, 8'h5A, -1, -1);
        chk("cplace_hit_nwr", wr_log.size() - log_base, 0);
        chk("cplace_hit_latency", done_cyc - start_cyc, 33);
        chk("cplace_hit_coll", collision, 1);

        // Place crossing the right edge.
        clear_board();
        run_op(1, 10, 0, 16'h000F, 8'h3C, -1, -1);
        chk("oob_nwr", wr_log.size() - log_base, 2);
        chk_log("oob0", 0, 10, 8'h3C);
        chk_log("oob1", 1, 11, 8'h3C);
        chk("oob_latency", done_cyc - start_cyc, 17);
        chk("oob_coll", collision, 1);

        // Erase a 2x2 block.
        preload(0, 8'h44); preload(1, 8'h44); preload(12, 8'h44); preload(13, 8'h44);
        run_op(2, 0, 0, 16'h0033, 8'h99, -1, -1);
        chk("erase_nwr", wr_log.size() - log_base, 4);
        chk_log("erase0", 0, 0, 0);
        chk_log("erase1", 1, 1, 0);
        chk_log("erase2", 2, 12, 0);
        chk_log("erase3", 3, 13, 0);
        chk("erase_coll", collision, 0);

        // Clean check-then-place with a start injected while busy.
        clear_board();
        run_op(3, 0, 5, 16'h000F, 8'h33, 5, -1);
        chk("cplace_latency", done_cyc - start_cyc, 49);
        chk("cplace_nwr", wr_log.size() - log_base, 4);
        chk_log("cplace0", 0, 60, 8'h33);
        chk("cplace_coll", collision, 0);

        // Reset in write cycle 2 aborts the operation.
        clear_board();
        run_op(1, 2, 2, 16'h000F, 8'h77, -1, 3);
        chk("abort_no_done", done_cyc, -1);
        chk("abort_nwr", wr_log.size() - log_base, 3);
        chk("abort_coll", collision, 0);

        // Next start is accepted and sees the partial piece.
        run_op(0, 2, 2, 16'h000F, 8'h00, -1, -1);
        chk("check_latency", done_cyc - start_cyc, 33);
        chk("check_coll", collision, 1);
        chk("check_nwr", wr_log.size() - log_base, 0);

        // Full box at the bottom-right corner, fully in bounds.
        clear_board();
        run_op(3, 8, 17, 16'hFFFF, 8'hC3, -1, -1);
        chk("corner_latency", done_cyc - start_cyc, 49);
        chk("corner_nwr", wr_log.size() - log_base, 16);
        chk_log("corner_last", 15, 251, 8'hC3);

        // Unmasked OOB cells never collide; a masked one does.
        clear_board();
        run_op(0, 9, 18, 16'h0001, 8'h00, -1, -1);
        chk("edge_free_coll", collision, 0);
        run_op(0, 9, 18, 16'h8000, 8'h00, -1, -1);
        chk("edge_oob_coll", collision, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
